// File: rtl/fmc_apb_pkg.sv
// fmc_apb_pkg: shared FSM state type and constants for the FMC-to-APB sequencer
package fmc_apb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;
  localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;
  localparam logic [31:0] APB_BASE_DEFAULT = 32'h4000_0000;
endpackage

// File: rtl/fmc_sync.sv
// fmc_sync: 2-flop synchronizer for an active-low strobe, resets to the inactive level
module fmc_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk)
    if (reset) {q, m} <= 2'b11;
    else {q, m} <= {m, d};
endmodule

// File: rtl/fmc_apb_sequencer.sv
// fmc_apb_sequencer: turns asynchronous FMC strobes into single APB transfers with wait and timeout
module fmc_apb_sequencer
  import fmc_apb_pkg::*;
#(
  parameter int          ADDR_W   = 26,
  parameter int          DATA_W   = 32,
  parameter logic [31:0] APB_BASE = APB_BASE_DEFAULT,
  parameter int          TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] io_fmc_A,
  input  logic [DATA_W-1:0] io_fmc_D_in,
  output logic [DATA_W-1:0] io_fmc_D_out,
  output logic              io_fmc_D_oe,
  input  logic              io_fmc_NE,
  input  logic              io_fmc_NOE,
  input  logic              io_fmc_NWE,
  output logic              io_fmc_NWAIT,
  output logic [31:0]       io_apb_PADDR,
  output logic              io_apb_PSEL,
  output logic              io_apb_PENABLE,
  output logic              io_apb_PWRITE,
  output logic [DATA_W-1:0] io_apb_PWDATA,
  output logic [3:0]        io_apb_PSTRB,
  output logic [2:0]        io_apb_PPROT,
  input  logic [DATA_W-1:0] io_apb_PRDATA,
  input  logic              io_apb_PREADY,
  input  logic              io_apb_PSLVERR,
  output logic              busy,
  output logic              err,
  input  logic              err_clr
);
  localparam logic [9:0] LAST = 10'(TIMEOUT - 1);
  state_t state;
  logic ne_s, noe_s, nwe_s;
  logic [9:0] cnt;
  logic [DATA_W-1:0] rdata;
  logic start, dual, done, tmo, err_set;
  fmc_sync u_ne  (.clk(clk), .reset(reset), .d(io_fmc_NE),  .q(ne_s));
  fmc_sync u_noe (.clk(clk), .reset(reset), .d(io_fmc_NOE), .q(noe_s));
  fmc_sync u_nwe (.clk(clk), .reset(reset), .d(io_fmc_NWE), .q(nwe_s));
  always_comb begin
    start   = state == IDLE && !ne_s && (noe_s ^ nwe_s);
    dual    = state == IDLE && !ne_s && !noe_s && !nwe_s;
    done    = state == ACCESS && io_apb_PREADY;
    tmo     = state == ACCESS && !io_apb_PREADY && cnt == LAST;
    err_set = dual || tmo || (done && io_apb_PSLVERR);
  end
  assign busy         = state != IDLE;
  assign io_apb_PPROT = 3'b000;
  assign io_fmc_D_out = rdata;
  assign io_fmc_D_oe  = state == HOLD && !io_apb_PWRITE && !noe_s;
  // PWRITE doubles as the latched direction (1 = write, i.e. NWE was the active strobe)
  always_ff @(posedge clk)
    if (reset) begin
      state          <= IDLE;
      io_apb_PSEL    <= 1'b0;
      io_apb_PENABLE <= 1'b0;
      io_apb_PWRITE  <= 1'b0;
      io_apb_PADDR   <= '0;
      io_apb_PWDATA  <= '0;
      io_apb_PSTRB   <= '0;
      io_fmc_NWAIT   <= 1'b1;
      rdata          <= '0;
      cnt            <= '0;
      err            <= 1'b0;
    end else begin
      err <= err_set | (err & ~err_clr);
      case (state)
        IDLE:
          if (start) begin
            state         <= SETUP;
            io_apb_PSEL   <= 1'b1;
            io_fmc_NWAIT  <= 1'b0;
            io_apb_PWRITE <= noe_s;
            io_apb_PADDR  <= APB_BASE | 32'({io_fmc_A, 2'b00});
            io_apb_PSTRB  <= noe_s ? 4'hF : 4'h0;
            if (noe_s) io_apb_PWDATA <= io_fmc_D_in;
          end else if (dual) begin
            state         <= HOLD;
            io_apb_PWRITE <= 1'b0;
            rdata         <= '0;
          end
        SETUP: begin
          state          <= ACCESS;
          io_apb_PENABLE <= 1'b1;
          cnt            <= '0;
        end
        ACCESS:
          if (done || tmo) begin
            state          <= HOLD;
            io_apb_PSEL    <= 1'b0;
            io_apb_PENABLE <= 1'b0;
            io_fmc_NWAIT   <= 1'b1;
            if (!io_apb_PWRITE) rdata <= done ? io_apb_PRDATA : DATA_W'(DEAD_BEEF);
          end else cnt <= cnt + 10'd1;
        HOLD: if (ne_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fmc_apb_sequencer.sv
// tb_fmc_apb_sequencer: table-driven transactions plus hand sequences for latency, dual strobe and reset
module tb_fmc_apb_sequencer;
  logic clk = 0, reset = 1;
  logic [25:0] io_fmc_A = '0;
  logic [31:0] io_fmc_D_in = '0, io_fmc_D_out, io_apb_PADDR, io_apb_PWDATA, io_apb_PRDATA = '0;
  logic io_fmc_D_oe, io_fmc_NWAIT, io_apb_PSEL, io_apb_PENABLE, io_apb_PWRITE, busy, err;
  logic io_fmc_NE = 1, io_fmc_NOE = 1, io_fmc_NWE = 1;
  logic io_apb_PREADY = 0, io_apb_PSLVERR = 0, err_clr = 0;
  logic [3:0] io_apb_PSTRB;
  logic [2:0] io_apb_PPROT;
  int pass_n = 0, total_n = 0;
  always #5 clk = ~clk;
  fmc_apb_sequencer #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .io_fmc_A(io_fmc_A), .io_fmc_D_in(io_fmc_D_in),
    .io_fmc_D_out(io_fmc_D_out), .io_fmc_D_oe(io_fmc_D_oe), .io_fmc_NE(io_fmc_NE),
    .io_fmc_NOE(io_fmc_NOE), .io_fmc_NWE(io_fmc_NWE), .io_fmc_NWAIT(io_fmc_NWAIT),
    .io_apb_PADDR(io_apb_PADDR), .io_apb_PSEL(io_apb_PSEL), .io_apb_PENABLE(io_apb_PENABLE),
    .io_apb_PWRITE(io_apb_PWRITE), .io_apb_PWDATA(io_apb_PWDATA), .io_apb_PSTRB(io_apb_PSTRB),
    .io_apb_PPROT(io_apb_PPROT), .io_apb_PRDATA(io_apb_PRDATA), .io_apb_PREADY(io_apb_PREADY),
    .io_apb_PSLVERR(io_apb_PSLVERR), .busy(busy), .err(err), .err_clr(err_clr)
  );
  typedef struct {
    logic wr; logic [25:0] a; logic [31:0] d; logic [31:0] prd; int waits; logic slverr;
    logic [31:0] e_paddr; logic [31:0] e_dout; int e_en; logic e_err;
  } vec_t;
  vec_t v[7];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic release_fmc();
    io_fmc_NE = 1; io_fmc_NOE = 1; io_fmc_NWE = 1; io_apb_PREADY = 0; io_apb_PSLVERR = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("back_to_idle", busy, 0);
  endtask
  task automatic clear_err();
    chk("err_sticky", err, 1);
    @(negedge clk); err_clr = 1;
    @(negedge clk); err_clr = 0;
    chk("err_cleared", err, 0);
  endtask
  task automatic run(input int idx, input vec_t t);
    int su = 0, en = 0;
    logic nw_bad = 0;
    logic [31:0] pa = '0, pwd = '0;
    logic [3:0] ps = '0;
    logic pw = 0;
    @(negedge clk);
    io_fmc_A = t.a; io_fmc_D_in = t.d; io_apb_PRDATA = t.prd; io_fmc_NE = 0;
    if (t.wr) io_fmc_NWE = 0; else io_fmc_NOE = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (io_apb_PSEL && !io_apb_PENABLE) begin su++; pa = io_apb_PADDR; pw = io_apb_PWRITE; ps = io_apb_PSTRB; pwd = io_apb_PWDATA; end
      if (io_apb_PSEL && io_fmc_NWAIT) nw_bad = 1;
      if (io_apb_PENABLE) begin
        en++;
        io_apb_PREADY = en > t.waits;
        io_apb_PSLVERR = t.slverr;
      end else if (en > 0) break;
    end
    io_apb_PREADY = 0; io_apb_PSLVERR = 0;
    $display("vector %0d", idx);
    chk("setup_cycles", su, 1);
    chk("penable_cycles", en, t.e_en);
    chk("paddr", pa, t.e_paddr);
    chk("pwrite", {31'b0, pw}, {31'b0, t.wr});
    chk("pstrb", {28'b0, ps}, t.wr ? 32'hF : 32'h0);
    if (t.wr) chk("pwdata", pwd, t.d);
    chk("nwait_low_during_xfer", {31'b0, nw_bad}, 0);
    chk("hold_busy", busy, 1);
    chk("hold_nwait", io_fmc_NWAIT, 1);
    chk("hold_psel", io_apb_PSEL, 0);
    chk("hold_d_oe", io_fmc_D_oe, !t.wr);
    if (!t.wr) chk("hold_d_out", io_fmc_D_out, t.e_dout);
    chk("hold_err", err, t.e_err);
    release_fmc();
    if (t.e_err) clear_err();
  endtask
  initial begin
    logic saw;
    v[0] = '{0, 26'h0004000, 32'h0, 32'h1234_5678, 0, 0, 32'h4001_0000, 32'h1234_5678, 1, 0};
    v[1] = '{1, 26'h0000010, 32'hCAFE_0001, 32'h0, 0, 0, 32'h4000_0040, 32'h0, 1, 0};
    v[2] = '{0, 26'h3FFFFFF, 32'h0, 32'hA5A5_5A5A, 5, 0, 32'h4FFF_FFFC, 32'hA5A5_5A5A, 6, 0};
    v[3] = '{1, 26'h0000123, 32'h0F0F_1234, 32'h0, 7, 0, 32'h4000_048C, 32'h0, 8, 0};
    v[4] = '{0, 26'h0000200, 32'h0, 32'h0BAD_F00D, 2, 1, 32'h4000_0800, 32'h0BAD_F00D, 3, 1};
    v[5] = '{0, 26'h0000001, 32'h0, 32'h1111_1111, 100, 0, 32'h4000_0004, 32'hDEAD_BEEF, 8, 1};
    v[6] = '{1, 26'h0000002, 32'h5555_AAAA, 32'h0, 100, 0, 32'h4000_0008, 32'h0, 8, 1};
    repeat (3) @(negedge clk);
    chk("rst_psel", io_apb_PSEL, 0);
    chk("rst_penable", io_apb_PENABLE, 0);
    chk("rst_pwrite", io_apb_PWRITE, 0);
    chk("rst_paddr", io_apb_PADDR, 0);
    chk("rst_pwdata", io_apb_PWDATA, 0);
    chk("rst_pstrb", {28'b0, io_apb_PSTRB}, 0);
    chk("rst_pprot", {29'b0, io_apb_PPROT}, 0);
    chk("rst_d_out", io_fmc_D_out, 0);
    chk("rst_d_oe", io_fmc_D_oe, 0);
    chk("rst_nwait", io_fmc_NWAIT, 1);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    reset = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 7; i++) run(i, v[i]);
    // best-case latency: strobe synchronized after two edges, PSEL one cycle later, PENABLE the next
    @(negedge clk);
    io_fmc_A = 26'h7; io_apb_PRDATA = 32'h7777_0007; io_fmc_NE = 0; io_fmc_NOE = 0;
    @(negedge clk); chk("lat_c1_psel", io_apb_PSEL, 0);
    @(negedge clk); chk("lat_c2_psel", io_apb_PSEL, 0);
    @(negedge clk); chk("lat_c3_psel", io_apb_PSEL, 1); chk("lat_c3_penable", io_apb_PENABLE, 0);
    @(negedge clk); chk("lat_c4_penable", io_apb_PENABLE, 1); io_apb_PREADY = 1;
    @(negedge clk); chk("lat_c5_psel", io_apb_PSEL, 0); chk("lat_c5_d_out", io_fmc_D_out, 32'h7777_0007);
    release_fmc();
    // dual strobe from idle: no APB transfer, error, read data 0
    @(negedge clk);
    io_fmc_NE = 0; io_fmc_NOE = 0; io_fmc_NWE = 0;
    saw = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (io_apb_PSEL) saw = 1; end
    chk("dual_no_psel", {31'b0, saw}, 0);
    chk("dual_busy", busy, 1);
    chk("dual_err", err, 1);
    chk("dual_d_out", io_fmc_D_out, 0);
    chk("dual_d_oe", io_fmc_D_oe, 1);
    release_fmc();
    clear_err();
    // reset in ACCESS, then both strobes low together
    @(negedge clk);
    io_fmc_A = 26'h5; io_fmc_NE = 0; io_fmc_NOE = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (io_apb_PENABLE) break; end
    chk("rstx_in_access", io_apb_PENABLE, 1);
    reset = 1; io_fmc_NWE = 0;
    @(negedge clk);
    chk("rstx_psel", io_apb_PSEL, 0);
    chk("rstx_penable", io_apb_PENABLE, 0);
    chk("rstx_busy", busy, 0);
    chk("rstx_nwait", io_fmc_NWAIT, 1);
    reset = 0;
    saw = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (io_apb_PSEL) saw = 1; end
    chk("rstx_dual_no_psel", {31'b0, saw}, 0);
    chk("rstx_dual_err", err, 1);
    chk("rstx_dual_busy", busy, 1);
    release_fmc();
    clear_err();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d", pass_n, total_n);
    $fatal(1);
  end
endmodule

// File: doc/fmc_apb_sequencer.md
FMC_APB_SEQUENCER -- requirements
Module: fmc_apb_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 26, width of the FMC address bus.
REQ-002 SHALL have parameter DATA_W, default 32, width of the FMC and APB data buses.
REQ-003 SHALL have parameter APB_BASE, default 32'h4000_0000, base address OR-ed into PADDR.
REQ-004 SHALL have parameter TIMEOUT, default 255, the maximum ACCESS-phase cycles before abort (legal range 1..1023).
REQ-005 SHALL have ports, in this order:
- clk, input, 1: the only clock.
- reset, input, 1: synchronous, active-high.
- io_fmc_A, input, ADDR_W: FMC word address.
- io_fmc_D_in, input, DATA_W: FMC write data.
- io_fmc_D_out, output, DATA_W: FMC read data.
- io_fmc_D_oe, output, 1: read-data output enable.
- io_fmc_NE, input, 1: chip enable, active-low.
- io_fmc_NOE, input, 1: output enable, active-low.
- io_fmc_NWE, input, 1: write enable, active-low.
- io_fmc_NWAIT, output, 1: wait, active-low.
- io_apb_PADDR, output, 32: APB address.
- io_apb_PSEL, output, 1: APB select.
- io_apb_PENABLE, output, 1: APB enable.
- io_apb_PWRITE, output, 1: APB write.
- io_apb_PWDATA, output, DATA_W: APB write data.
- io_apb_PSTRB, output, 4: APB byte strobes.
- io_apb_PPROT, output, 3: APB protection.
- io_apb_PRDATA, input, DATA_W: APB read data.
- io_apb_PREADY, input, 1: APB ready.
- io_apb_PSLVERR, input, 1: APB slave error.
- busy, output, 1: transaction in progress.
- err, output, 1: sticky error flag.
- err_clr, input, 1: clears err.

Function
REQ-006 SHALL pass NE, NOE and NWE through 2-flop synchronizers that reset to 1; all decisions SHALL use the synchronized values (neS, noeS, nweS).
REQ-007 SHALL implement the FSM states IDLE, SETUP, ACCESS and HOLD.
REQ-008 IDLE SHALL move to SETUP when neS=0 and exactly one of noeS or nweS is 0.
- On that transition it SHALL capture A, capture D_in (write only), and latch the direction.
REQ-009 IDLE with neS=0 and noeS=nweS=0 SHALL go directly to HOLD, set err, start no APB transfer, and return read data 0.
REQ-010 In SETUP, PSEL SHALL be 1 and PENABLE 0, for exactly one cycle; the next state SHALL be ACCESS.
REQ-011 In ACCESS, PSEL and PENABLE SHALL both be 1.
- On PREADY=1 the FSM SHALL go to HOLD and register PRDATA (read).
- PSLVERR=1 with PREADY=1 SHALL set err.
REQ-012 If PREADY stays 0 for TIMEOUT cycles in ACCESS, the FSM SHALL abort to HOLD, set err, and return read data 32'hDEAD_BEEF.
REQ-013 APB address, data and control SHALL come from the captured values:
- PADDR = APB_BASE | {A, 2'b00}, truncated to 32 bits.
- PWRITE = captured direction.
- PSTRB = 4'hF on write, 0 on read.
- PPROT = 3'b000.
REQ-014 io_fmc_NWAIT SHALL be 0 from the cycle after IDLE detects a transaction until entry to HOLD, and 1 otherwise.
REQ-015 In HOLD, D_out SHALL carry the registered read data, and D_oe SHALL be 1 iff the transfer was a read and noeS=0.
REQ-016 HOLD SHALL return to IDLE when neS=1; a new transaction SHALL require neS to go high first (no back-to-back without NE deassertion).
REQ-017 busy SHALL be 1 in every state other than IDLE.
REQ-018 err_clr SHALL clear err unless a new error is set in the same cycle, in which case set wins.
REQ-019 Best-case APB latency SHALL be: synchronized strobe seen at cycle n, PSEL at n+1, PENABLE at n+2, completion at n+2 when PREADY=1.

Reset
REQ-020 While reset=1, the following SHALL hold on the next clk edge:
- State = IDLE.
- PSEL=0, PENABLE=0, PWRITE=0.
- PADDR, PWDATA, PSTRB and D_out = 0.
- D_oe=0, NWAIT=1, busy=0, err=0.
- Synchronizers = 1.
- Timeout counter = 0.
REQ-021 Reset mid-transfer SHALL abandon the APB transfer immediately; PSEL SHALL fall on the following edge.

Structure
REQ-022 Package fmc_apb_pkg SHALL hold the FSM state enumeration, the DEAD_BEEF constant, and the APB_BASE default.
REQ-023 The 2-flop synchronizer SHALL be a sub-module fmc_sync, instantiated once per strobe.

Verification
REQ-024 Read: NE=0, NOE=0, A=26'h4000, PRDATA=32'h1234_5678 with PREADY=1 in ACCESS -> PADDR=32'h4001_0000, PWRITE=0, D_out=32'h1234_5678 with D_oe=1 in HOLD, and NWAIT back to 1.
REQ-025 Write: NE=0, NWE=0, A=26'h0010, D=32'hCAFE_0001 -> exactly one SETUP/ACCESS pair with PADDR=32'h4000_0040, PWDATA=32'hCAFE_0001, PSTRB=4'hF.
REQ-026 Wait states: PREADY held 0 for 5 ACCESS cycles -> PENABLE high 6 cycles and NWAIT low throughout; err stays 0.
REQ-027 Timeout: PREADY never asserted, TIMEOUT=8 -> abort after 8 ACCESS cycles, read returns 32'hDEAD_BEEF, and err=1 until err_clr is pulsed.
REQ-028 Reset asserted during ACCESS, then NOE and NWE low together -> PSEL=0 on the next edge; the later dual strobe causes no APB transfer and sets err.
